// File: rtl/bash_state_squeeze.sv
// Word-serial output stage: captures a full bash-f state in one transfer and
// streams the first cnt words out on a valid/ready interface.
module bash_state_squeeze #(
  parameter int unsigned SLEN   = 64,
  parameter int unsigned NWORDS = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid_i,
  output logic                   load_ready_o,
  input  logic [NWORDS*SLEN-1:0] state_i,
  input  logic [4:0]             len_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [SLEN-1:0]        out_data_o,
  output logic [4:0]             out_idx_o,
  output logic                   out_last_o,
  output logic                   busy_o
);

  localparam logic [4:0] NWordsL = 5'(NWORDS);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e          state_q;
  logic [4:0]      cnt_q;
  logic [4:0]      idx_q;
  logic            last_q;
  logic [SLEN-1:0] buf_q [NWORDS];

  logic            load_fire;
  logic [4:0]      len_eff;

  assign load_fire = (state_q == StIdle) && load_valid_i;

  // Zero or oversized lengths emit the whole state.
  assign len_eff = ((len_i == 5'd0) || (len_i > NWordsL)) ? NWordsL : len_i;

  // Control FSM; last flag is precomputed so it is a plain register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_valid_i) begin
            state_q <= StStream;
            cnt_q   <= len_eff;
            idx_q   <= '0;
            last_q  <= (len_eff == 5'd1);
          end
        end
        StStream: begin
          if (out_ready_i) begin
            if (last_q) begin
              state_q <= StIdle;
              idx_q   <= '0;
              last_q  <= 1'b0;
            end else begin
              idx_q  <= idx_q + 5'd1;
              // Next word is final when idx+1 == cnt-1.
              last_q <= ((idx_q + 5'd2) == cnt_q);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // State buffer: written only on an accepted load, so never touched mid-stream.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      for (int k = 0; k < NWORDS; k++) begin
        buf_q[k] <= state_i[k*SLEN +: SLEN];
      end
    end
  end

  // Outputs decoded from registers only; data forced to zero outside STREAM.
  always_comb begin
    load_ready_o = (state_q == StIdle);
    out_valid_o  = (state_q == StStream);
    busy_o       = (state_q == StStream);
    out_idx_o    = idx_q;
    out_last_o   = last_q;
    out_data_o   = (state_q == StStream) ? buf_q[idx_q] : '0;
  end

endmodule
